ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 16-bit, 5-stage pipeline; sits directly downstream of ID_stage.
//  Consumes the ID/EX bundle, resolves RAW hazards by forwarding from EX/MEM and MEM/WB,
//  runs the 8-op ALU and registers the EX/MEM bundle for the memory stage.
//  Also owns load-use detection: drives the stall into ID_stage, which then inserts a bubble.
// PARAMETERS
//  DW      16  datapath width
//  RW      3   register-address width; address 0 is never a forwarding source or target
//  SHW     4   shift-amount bits taken from operand B
// PORTS
//  clk                 in   1   pipeline clock
//  rst                 in   1   synchronous, active-high reset
//  id_ex_alu_cmd       in   3   ALU command from ID
//  id_ex_rs1_data      in   DW  operand A (register-file value)
//  id_ex_rs2_data      in   DW  operand B (register value or sign-extended imm)
//  id_ex_store_data    in   DW  store value (register-file value)
//  id_ex_op_dest       in   RW  destination register
//  id_ex_mem_write_en  in   1   store
//  id_ex_wb_mux        in   1   1 = load (writeback from memory)
//  id_ex_wb_en         in   1   writes a register
//  fsrc1, fsrc2        in   RW  operand A/B source addresses; 0 = no forwarding
//  fsrc_st             in   RW  store-data source address; 0 = no forwarding
//  id_rs1_addr         in   RW  source addresses of the instruction now in ID
//  id_rs2_addr         in   RW  (for load-use check)
//  mem_wb_wb_en        in   1   MEM/WB writes a register
//  mem_wb_op_dest      in   RW  MEM/WB destination
//  mem_wb_data         in   DW  final MEM/WB writeback value
//  stall               out  1   load-use stall to IF/ID (combinational)
//  ex_mem_alu_result   out  DW  registered ALU result / memory address
//  ex_mem_store_data   out  DW  registered forwarded store value
//  ex_mem_op_dest, ex_mem_mem_write_en, ex_mem_wb_mux, ex_mem_wb_en  out  registered control copies
// BEHAVIOUR
//  - Reset: all ex_mem_* outputs 0 on the first clk edge with rst=1; the reset state is a bubble.
//    stall is 0 while rst=1.
//  - Latency: 1 cycle. The ID/EX bundle sampled at edge N appears on ex_mem_* after edge N.
//    No enable; a bubble (all-zero) input propagates as a bubble.
//  - Forwarding: applied per source independently to A (fsrc1), B (fsrc2) and store data (fsrc_st):
//    * src!=0 && ex_mem_wb_en && !ex_mem_wb_mux && ex_mem_op_dest==src -> ex_mem_alu_result
//    * else src!=0 && mem_wb_wb_en && mem_wb_op_dest==src               -> mem_wb_data
//    * else the id_ex_* value
//    EX/MEM takes priority over MEM/WB when both match (younger producer wins).
//  - ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SHL, 7 SHR (logical).
//    * ADD/SUB: modulo 2^16, no flags.
//    * Shifts: shift A by B[SHW-1:0]; B[15:4] is ignored.
//  - Load-use: stall = id_ex_wb_mux && id_ex_wb_en && id_ex_op_dest!=0 &&
//    (id_ex_op_dest==id_rs1_addr || id_ex_op_dest==id_rs2_addr).
//    * ID zeroes ID/EX for one cycle; the next cycle the load sits in EX/MEM, stall drops, and
//      the consumer later forwards from MEM/WB.
//    * The EX/MEM load match path is therefore never taken.
//  - Store whose data register is written by the immediately preceding ALU op forwards via fsrc_st.
//  - rst mid-operation: in-flight EX/MEM contents are discarded; no partial writes are issued.
// STRUCTURE
//  - Shared defines file: ALU_ADD..ALU_SHR codes, opcode values, DW/RW widths.
//  - Sub-module alu16: combinational, inputs (cmd, a, b), output y.
//  - ex_stage holds the three forwarding muxes, the hazard compare and the EX/MEM register.
// TESTING
//  - rst=1 with non-zero inputs for 2 cycles -> all ex_mem_* = 0 and stall = 0.
//  - ADD r1=5 then SUB with fsrc1=1, rs1_data stale=0, rs2=2 -> result 3 (EX/MEM forward).
//  - r2 produced 2 cycles earlier: mem_wb dest=2, data=0x00F0; AND with fsrc2=2, A=0x0FFF
//    -> 0x00F0 (MEM/WB forward).
//  - Both stages write r3 (EX/MEM=7, MEM/WB=9); ADD fsrc1=3, B=1 -> 8 (priority check).
//  - LD r4 in ID/EX, id_rs2_addr=4 -> stall=1 for exactly 1 cycle; with id_rs1_addr=0 and
//    dest=0 -> stall=0.
//  - SHL A=0x0001, B=0x0013 -> 0x0008; SUB 0-1 -> 0xFFFF; NOR 0,0 -> 0xFFFF.
//  - ST with fsrc_st=5 after ADD r5=0x1234 -> ex_mem_store_data=0x1234, ex_mem_mem_write_en=1.

Source files
------------

// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_pkg
// Description : Shared widths, ALU command codes, EX/MEM bundle type and the
//               operand-forwarding select used by the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

    localparam int DW  = 16;
    localparam int RW  = 3;
    localparam int SHW = 4;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOR = 3'd4,
        ALU_XOR = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_cmd_e;

    typedef struct packed {
        logic [DW-1:0] alu_result;
        logic [DW-1:0] store_data;
        logic [RW-1:0] op_dest;
        logic          mem_write_en;
        logic          wb_mux;
        logic          wb_en;
    } ex_mem_t;

    // A load in EX/MEM has no data yet, so it is excluded from the younger path.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] src,
        input logic [DW-1:0] id_val,
        input logic          exm_wb_en,
        input logic          exm_wb_mux,
        input logic [RW-1:0] exm_dest,
        input logic [DW-1:0] exm_val,
        input logic          mwb_wb_en,
        input logic [RW-1:0] mwb_dest,
        input logic [DW-1:0] mwb_val
    );
        logic [DW-1:0] v;
        v = id_val;
        if (src != '0 && exm_wb_en && !exm_wb_mux && exm_dest == src)
            v = exm_val;
        else if (src != '0 && mwb_wb_en && mwb_dest == src)
            v = mwb_val;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_if
// Description : ID/EX, MEM/WB feedback, hazard and EX/MEM signals of the
//               execute stage; slave modport is the stage, master its drivers.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic [2:0]    id_ex_alu_cmd;
    logic [DW-1:0] id_ex_rs1_data;
    logic [DW-1:0] id_ex_rs2_data;
    logic [DW-1:0] id_ex_store_data;
    logic [RW-1:0] id_ex_op_dest;
    logic          id_ex_mem_write_en;
    logic          id_ex_wb_mux;
    logic          id_ex_wb_en;
    logic [RW-1:0] fsrc1;
    logic [RW-1:0] fsrc2;
    logic [RW-1:0] fsrc_st;
    logic [RW-1:0] id_rs1_addr;
    logic [RW-1:0] id_rs2_addr;
    logic          mem_wb_wb_en;
    logic [RW-1:0] mem_wb_op_dest;
    logic [DW-1:0] mem_wb_data;
    logic          stall;
    logic [DW-1:0] ex_mem_alu_result;
    logic [DW-1:0] ex_mem_store_data;
    logic [RW-1:0] ex_mem_op_dest;
    logic          ex_mem_mem_write_en;
    logic          ex_mem_wb_mux;
    logic          ex_mem_wb_en;

    modport slave (
        input  id_ex_alu_cmd, id_ex_rs1_data, id_ex_rs2_data, id_ex_store_data,
        input  id_ex_op_dest, id_ex_mem_write_en, id_ex_wb_mux, id_ex_wb_en,
        input  fsrc1, fsrc2, fsrc_st, id_rs1_addr, id_rs2_addr,
        input  mem_wb_wb_en, mem_wb_op_dest, mem_wb_data,
        output stall, ex_mem_alu_result, ex_mem_store_data, ex_mem_op_dest,
        output ex_mem_mem_write_en, ex_mem_wb_mux, ex_mem_wb_en
    );

    modport master (
        output id_ex_alu_cmd, id_ex_rs1_data, id_ex_rs2_data, id_ex_store_data,
        output id_ex_op_dest, id_ex_mem_write_en, id_ex_wb_mux, id_ex_wb_en,
        output fsrc1, fsrc2, fsrc_st, id_rs1_addr, id_rs2_addr,
        output mem_wb_wb_en, mem_wb_op_dest, mem_wb_data,
        input  stall, ex_mem_alu_result, ex_mem_store_data, ex_mem_op_dest,
        input  ex_mem_mem_write_en, ex_mem_wb_mux, ex_mem_wb_en
    );

endinterface
`default_nettype wire

// File: rtl/ex_stage_alu16.sv
`default_nettype none
// ============================================================================
// Module      : alu16
// Description : Combinational 8-operation ALU; shifts use the low SHW bits of b.
// Revision    : 1.0 - initial release
// ============================================================================
module alu16
    import ex_stage_pkg::*;
(
    input  wire logic [2:0]    i_cmd,
    input  wire logic [DW-1:0] i_a,
    input  wire logic [DW-1:0] i_b,
    output      logic [DW-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (alu_cmd_e'(i_cmd))
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_NOR: o_y = ~(i_a | i_b);
            ALU_XOR: o_y = i_a ^ i_b;
            ALU_SHL: o_y = i_a << i_b[SHW-1:0];
            ALU_SHR: o_y = i_a >> i_b[SHW-1:0];
            default: o_y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage: operand/store forwarding, ALU, load-use stall
//               detection and the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    ex_stage_if.slave bus
);

    ex_mem_t       r_ex_mem;
    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_op_b;
    logic [DW-1:0] w_store;
    logic [DW-1:0] w_alu_y;

    assign w_op_a  = fwd_sel(bus.fsrc1, bus.id_ex_rs1_data,
                             r_ex_mem.wb_en, r_ex_mem.wb_mux, r_ex_mem.op_dest, r_ex_mem.alu_result,
                             bus.mem_wb_wb_en, bus.mem_wb_op_dest, bus.mem_wb_data);
    assign w_op_b  = fwd_sel(bus.fsrc2, bus.id_ex_rs2_data,
                             r_ex_mem.wb_en, r_ex_mem.wb_mux, r_ex_mem.op_dest, r_ex_mem.alu_result,
                             bus.mem_wb_wb_en, bus.mem_wb_op_dest, bus.mem_wb_data);
    assign w_store = fwd_sel(bus.fsrc_st, bus.id_ex_store_data,
                             r_ex_mem.wb_en, r_ex_mem.wb_mux, r_ex_mem.op_dest, r_ex_mem.alu_result,
                             bus.mem_wb_wb_en, bus.mem_wb_op_dest, bus.mem_wb_data);

    alu16 u_alu (
        .i_cmd (bus.id_ex_alu_cmd),
        .i_a   (w_op_a),
        .i_b   (w_op_b),
        .o_y   (w_alu_y)
    );

    // A load in EX whose result the instruction in ID needs cannot be forwarded in time.
    assign bus.stall = !rst && bus.id_ex_wb_mux && bus.id_ex_wb_en &&
                       (bus.id_ex_op_dest != '0) &&
                       ((bus.id_ex_op_dest == bus.id_rs1_addr) ||
                        (bus.id_ex_op_dest == bus.id_rs2_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_mem <= '0;
        end else begin
            r_ex_mem.alu_result   <= w_alu_y;
            r_ex_mem.store_data   <= w_store;
            r_ex_mem.op_dest      <= bus.id_ex_op_dest;
            r_ex_mem.mem_write_en <= bus.id_ex_mem_write_en;
            r_ex_mem.wb_mux       <= bus.id_ex_wb_mux;
            r_ex_mem.wb_en        <= bus.id_ex_wb_en;
        end
    end

    assign bus.ex_mem_alu_result   = r_ex_mem.alu_result;
    assign bus.ex_mem_store_data   = r_ex_mem.store_data;
    assign bus.ex_mem_op_dest      = r_ex_mem.op_dest;
    assign bus.ex_mem_mem_write_en = r_ex_mem.mem_write_en;
    assign bus.ex_mem_wb_mux       = r_ex_mem.wb_mux;
    assign bus.ex_mem_wb_en        = r_ex_mem.wb_en;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Directed self-checking bench for ex_stage with a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [15:0] m_res, m_st;
    logic [2:0]  m_dest;
    logic        m_we, m_mux, m_wen, m_valid;

    initial m_valid = 1'b0;

    function automatic logic [15:0] m_fwd(input logic [2:0] src, input logic [15:0] v);
        if (src != 0 && m_wen && !m_mux && m_dest == src) return m_res;
        if (src != 0 && bus.mem_wb_wb_en && bus.mem_wb_op_dest == src) return bus.mem_wb_data;
        return v;
    endfunction

    function automatic logic [15:0] m_alu(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b);
        int sh;
        sh = int'(b % 16);
        case (cmd)
            3'd0: return 16'((a + b) % 65536);
            3'd1: return 16'((32'(a) + 65536 - 32'(b)) % 65536);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ~(a | b);
            3'd5: return a ^ b;
            3'd6: return 16'((32'(a) * (1 << sh)) % 65536);
            default: return 16'(32'(a) / (1 << sh));
        endcase
    endfunction

    always @(posedge clk) begin
        logic [15:0] a, b, s;
        if (rst) begin
            m_res = 0; m_st = 0; m_dest = 0; m_we = 0; m_mux = 0; m_wen = 0;
            m_valid = 1'b1;
        end else begin
            a = m_fwd(bus.fsrc1, bus.id_ex_rs1_data);
            b = m_fwd(bus.fsrc2, bus.id_ex_rs2_data);
            s = m_fwd(bus.fsrc_st, bus.id_ex_store_data);
            m_res  = m_alu(bus.id_ex_alu_cmd, a, b);
            m_st   = s;
            m_dest = bus.id_ex_op_dest;
            m_we   = bus.id_ex_mem_write_en;
            m_mux  = bus.id_ex_wb_mux;
            m_wen  = bus.id_ex_wb_en;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic exp_stall;
        if (m_valid) begin
            exp_stall = !rst && bus.id_ex_wb_mux && bus.id_ex_wb_en && bus.id_ex_op_dest != 0 &&
                        (bus.id_ex_op_dest == bus.id_rs1_addr || bus.id_ex_op_dest == bus.id_rs2_addr);
            chk("cyc_alu_result", bus.ex_mem_alu_result, m_res);
            chk("cyc_store_data", bus.ex_mem_store_data, m_st);
            chk("cyc_op_dest",    16'(bus.ex_mem_op_dest), 16'(m_dest));
            chk("cyc_ctrl",       {13'd0, bus.ex_mem_mem_write_en, bus.ex_mem_wb_mux, bus.ex_mem_wb_en},
                                  {13'd0, m_we, m_mux, m_wen});
            chk("cyc_stall",      16'(bus.stall), 16'(exp_stall));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clr();
        bus.id_ex_alu_cmd = 0;      bus.id_ex_rs1_data = 0;    bus.id_ex_rs2_data = 0;
        bus.id_ex_store_data = 0;   bus.id_ex_op_dest = 0;     bus.id_ex_mem_write_en = 0;
        bus.id_ex_wb_mux = 0;       bus.id_ex_wb_en = 0;       bus.fsrc1 = 0;
        bus.fsrc2 = 0;              bus.fsrc_st = 0;           bus.id_rs1_addr = 0;
        bus.id_rs2_addr = 0;        bus.mem_wb_wb_en = 0;      bus.mem_wb_op_dest = 0;
        bus.mem_wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic alu_op(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b,
                          input string nm, input logic [15:0] exp);
        clr();
        bus.id_ex_alu_cmd = cmd; bus.id_ex_rs1_data = a; bus.id_ex_rs2_data = b;
        tick();
        chk(nm, bus.ex_mem_alu_result, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        // non-zero inputs during reset, including a would-be load-use hazard
        clr();
        bus.id_ex_alu_cmd = 3'd0; bus.id_ex_rs1_data = 16'h1111; bus.id_ex_rs2_data = 16'h2222;
        bus.id_ex_store_data = 16'h3333; bus.id_ex_op_dest = 3'd4; bus.id_ex_mem_write_en = 1;
        bus.id_ex_wb_mux = 1; bus.id_ex_wb_en = 1; bus.id_rs1_addr = 3'd4;
        tick();
        tick();
        chk("rst_alu_result", bus.ex_mem_alu_result, 16'h0000);
        chk("rst_store_data", bus.ex_mem_store_data, 16'h0000);
        chk("rst_ctrl", {10'd0, bus.ex_mem_op_dest, bus.ex_mem_mem_write_en, bus.ex_mem_wb_mux, bus.ex_mem_wb_en}, 16'h0000);
        chk("rst_stall", 16'(bus.stall), 16'h0000);

        rst = 1'b0;
        clr();
        tick();

        // EX/MEM forward
        clr(); bus.id_ex_rs1_data = 16'd5; bus.id_ex_op_dest = 3'd1; bus.id_ex_wb_en = 1;
        tick(); chk("add_r1", bus.ex_mem_alu_result, 16'd5);
        clr(); bus.id_ex_alu_cmd = 3'd1; bus.fsrc1 = 3'd1; bus.id_ex_rs2_data = 16'd2;
        bus.id_ex_op_dest = 3'd6; bus.id_ex_wb_en = 1;
        tick(); chk("sub_exm_fwd", bus.ex_mem_alu_result, 16'd3);

        // MEM/WB forward
        clr(); bus.id_ex_alu_cmd = 3'd2; bus.fsrc2 = 3'd2; bus.id_ex_rs1_data = 16'h0FFF;
        bus.mem_wb_wb_en = 1; bus.mem_wb_op_dest = 3'd2; bus.mem_wb_data = 16'h00F0;
        bus.id_ex_op_dest = 3'd7; bus.id_ex_wb_en = 1;
        tick(); chk("and_mwb_fwd", bus.ex_mem_alu_result, 16'h00F0);

        // priority: EX/MEM r3=7 beats MEM/WB r3=9
        clr(); bus.id_ex_rs1_data = 16'd7; bus.id_ex_op_dest = 3'd3; bus.id_ex_wb_en = 1;
        tick(); chk("add_r3", bus.ex_mem_alu_result, 16'd7);
        clr(); bus.fsrc1 = 3'd3; bus.id_ex_rs2_data = 16'd1;
        bus.mem_wb_wb_en = 1; bus.mem_wb_op_dest = 3'd3; bus.mem_wb_data = 16'd9;
        tick(); chk("fwd_priority", bus.ex_mem_alu_result, 16'd8);

        // load-use on rs2
        clr(); bus.id_ex_rs1_data = 16'h0010; bus.id_ex_op_dest = 3'd4;
        bus.id_ex_wb_mux = 1; bus.id_ex_wb_en = 1; bus.id_rs2_addr = 3'd4;
        #1 chk("ld_stall_rs2", 16'(bus.stall), 16'd1);
        tick(); chk("ld_wb_mux", 16'(bus.ex_mem_wb_mux), 16'd1);
        // a load in EX/MEM is never an operand source
        clr(); bus.fsrc1 = 3'd4; bus.id_ex_rs1_data = 16'h0100; bus.id_ex_rs2_data = 16'd1;
        bus.id_rs2_addr = 3'd4;
        #1 chk("stall_drops", 16'(bus.stall), 16'd0);
        tick(); chk("no_load_exm_fwd", bus.ex_mem_alu_result, 16'h0101);
        // load with dest 0 never stalls
        clr(); bus.id_ex_wb_mux = 1; bus.id_ex_wb_en = 1;
        #1 chk("ld_dest0_nostall", 16'(bus.stall), 16'd0);
        tick();
        // load-use on rs1
        clr(); bus.id_ex_op_dest = 3'd6; bus.id_ex_wb_mux = 1; bus.id_ex_wb_en = 1;
        bus.id_rs1_addr = 3'd6;
        #1 chk("ld_stall_rs1", 16'(bus.stall), 16'd1);
        tick();

        // ALU corners
        alu_op(3'd6, 16'h0001, 16'h0013, "shl_mask", 16'h0008);
        alu_op(3'd1, 16'h0000, 16'h0001, "sub_wrap", 16'hFFFF);
        alu_op(3'd4, 16'h0000, 16'h0000, "nor_zero", 16'hFFFF);
        alu_op(3'd3, 16'hF000, 16'h000F, "or",       16'hF00F);
        alu_op(3'd5, 16'hFF00, 16'h0FF0, "xor",      16'hF0F0);
        alu_op(3'd7, 16'h8000, 16'h002F, "shr_log",  16'h0001);
        alu_op(3'd0, 16'hFFFF, 16'h0002, "add_wrap", 16'h0001);

        // store data forwarding
        clr(); bus.id_ex_rs1_data = 16'h1000; bus.id_ex_rs2_data = 16'h0234;
        bus.id_ex_op_dest = 3'd5; bus.id_ex_wb_en = 1;
        tick(); chk("add_r5", bus.ex_mem_alu_result, 16'h1234);
        clr(); bus.id_ex_rs1_data = 16'h0020; bus.fsrc_st = 3'd5; bus.id_ex_mem_write_en = 1;
        tick();
        chk("st_exm_fwd", bus.ex_mem_store_data, 16'h1234);
        chk("st_we", 16'(bus.ex_mem_mem_write_en), 16'd1);
        chk("st_addr", bus.ex_mem_alu_result, 16'h0020);
        clr(); bus.id_ex_rs1_data = 16'h0022; bus.fsrc_st = 3'd5; bus.id_ex_mem_write_en = 1;
        bus.id_ex_store_data = 16'h0BAD;
        bus.mem_wb_wb_en = 1; bus.mem_wb_op_dest = 3'd5; bus.mem_wb_data = 16'hBEEF;
        tick(); chk("st_mwb_fwd", bus.ex_mem_store_data, 16'hBEEF);
        clr(); bus.id_ex_store_data = 16'h0BAD; bus.fsrc_st = 3'd0; bus.id_ex_mem_write_en = 1;
        bus.mem_wb_wb_en = 1; bus.mem_wb_op_dest = 3'd0; bus.mem_wb_data = 16'hBEEF;
        tick(); chk("st_r0_nofwd", bus.ex_mem_store_data, 16'h0BAD);

        // reset mid-operation discards in-flight contents
        clr(); bus.id_ex_rs1_data = 16'h0055; bus.id_ex_op_dest = 3'd2; bus.id_ex_wb_en = 1;
        bus.id_ex_mem_write_en = 1;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_result", bus.ex_mem_alu_result, 16'h0000);
        chk("midrst_ctrl", {13'd0, bus.ex_mem_mem_write_en, bus.ex_mem_wb_mux, bus.ex_mem_wb_en}, 16'h0000);
        rst = 1'b0;
        clr();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
